prj_processor_cpu_cpu_debug_mem_sequencer: RTL and testbench

//  Sysclk-domain controller that turns debug-slave action strobes into accesses on the
//  on-chip debug memory (OCI RAM). It sits between the debug-slave sysclk logic and the
//  OCI RAM port, which it shares with no other master.
//  It owns the auto-incrementing address, sequences each read/write with a waitrequest

---
 rtl/prj_processor_cpu_cpu_debug_mem_sequencer.sv | 122 ++++++++++++
 tb/tb_prj_processor_cpu_cpu_debug_mem_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prj_processor_cpu_cpu_debug_mem_sequencer.sv
// Debug-memory access sequencer: turns debug-slave strobes into OCI RAM reads/writes
// with an auto-incrementing address, waitrequest handshake, timeout and sticky error.
module prj_processor_cpu_cpu_debug_mem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [31:0]        wdata_n, mon_n;
    logic               rd_n, wr_n, ready_n, err_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               any_strobe, multi_strobe;
    logic               unused_jdo;

    assign unused_jdo   = ^{jdo[37:35], jdo[2:0]};
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                          (take_action_ocimem_a & take_no_action_ocimem_a) |
                          (take_action_ocimem_b & take_no_action_ocimem_a);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            cnt           <= '0;
        end else begin
            state         <= state_n;
            mem_addr      <= addr_n;
            mem_wdata     <= wdata_n;
            mem_rd        <= rd_n;
            mem_wr        <= wr_n;
            MonDReg       <= mon_n;
            monitor_ready <= ready_n;
            monitor_error <= err_n;
            cnt           <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        rd_n    = mem_rd;
        wr_n    = mem_wr;
        mon_n   = MonDReg;
        ready_n = monitor_ready;
        err_n   = monitor_error;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                // Load beats write beats read; any collision is flagged after the winner runs.
                if (take_action_ocimem_a) begin
                    addr_n = jdo[ADDR_W+16:17];
                    err_n  = multi_strobe;
                end else if (take_action_ocimem_b) begin
                    wdata_n = jdo[34:3];
                    mon_n   = jdo[34:3];
                    wr_n    = 1'b1;
                    ready_n = 1'b0;
                    cnt_n   = '0;
                    state_n = WR;
                    if (multi_strobe) err_n = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    rd_n    = 1'b1;
                    ready_n = 1'b0;
                    cnt_n   = '0;
                    state_n = RD;
                end
            end
            WR, RD: begin
                if (any_strobe) err_n = 1'b1;
                if (!mem_waitrequest) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    if (state == RD) mon_n = mem_rdata;
                    addr_n  = mem_addr + ADDR_W'(1);
                    ready_n = 1'b1;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // Abort: address and MonDReg keep their values so the host can retry.
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    err_n   = 1'b1;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prj_processor_cpu_cpu_debug_mem_sequencer.sv
// Randomized bench for the debug-memory sequencer with a transaction-level reference model.
module tb_prj_processor_cpu_cpu_debug_mem_sequencer;

    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   jdo;
    logic          act_a, act_b, noact_a;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_waitrequest;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;

    int tests = 0;
    int fails = 0;

    logic [31:0]   ram     [256];
    logic [31:0]   ref_mem [256];
    logic [AW-1:0] m_addr;
    logic [31:0]   m_mon;
    logic          m_err;

    prj_processor_cpu_cpu_debug_mem_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(act_a), .take_action_ocimem_b(act_b),
        .take_no_action_ocimem_a(noact_a),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_waitrequest(mem_waitrequest),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        tests++; if (mem_addr !== '0) begin fails++; $display("FAIL rst_addr: got %h expected 00", mem_addr); end
        tests++; if ({mem_rd, mem_wr} !== 2'b00) begin fails++; $display("FAIL rst_req: got %b expected 00", {mem_rd, mem_wr}); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h expected 0", mem_wdata); end
        tests++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL rst_mon: got %h expected 0", MonDReg); end
        tests++; if ({monitor_ready, monitor_error} !== 2'b10) begin fails++; $display("FAIL rst_status: got %b expected 10", {monitor_ready, monitor_error}); end
        reset = 1'b0;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a_val, input bit extra);
        @(negedge clk);
        jdo = {6'($urandom()), $urandom()};
        jdo[24:17] = a_val;
        act_a = 1'b1; act_b = extra;
        @(negedge clk);
        act_a = 1'b0; act_b = 1'b0;
        m_addr = a_val;
        m_err  = extra;
        tests++; if (mem_addr !== m_addr) begin fails++; $display("FAIL load_addr: got %h expected %h", mem_addr, m_addr); end
        tests++; if (monitor_error !== m_err) begin fails++; $display("FAIL load_err: got %b expected %b", monitor_error, m_err); end
        tests++; if ({mem_rd, mem_wr, monitor_ready} !== 3'b001) begin fails++; $display("FAIL load_idle: got %b expected 001", {mem_rd, mem_wr, monitor_ready}); end
    endtask

    // stray: 0 none, 1 load, 2 write, 3 read strobe in first request cycle; multi: read alongside write
    task automatic do_access(input bit is_wr, input logic [31:0] data, input int waits,
                             input int stray, input bit multi);
        int k;
        int exp_cnt;
        bit acc;
        @(negedge clk);
        jdo = {6'($urandom()), $urandom()};
        jdo[34:3] = data;
        if (is_wr) begin act_b = 1'b1; noact_a = multi; end
        else noact_a = 1'b1;
        @(negedge clk);
        act_b = 1'b0; noact_a = 1'b0;
        acc = (waits < TO);
        k = 0;
        while (k < TO + 3 && (mem_rd || mem_wr)) begin
            k++;
            tests++; if ({mem_wr, mem_rd} !== {is_wr, !is_wr}) begin fails++; $display("FAIL req_kind: got wr/rd %b expected %b", {mem_wr, mem_rd}, {is_wr, !is_wr}); end
            tests++; if (mem_addr !== m_addr) begin fails++; $display("FAIL req_addr: got %h expected %h", mem_addr, m_addr); end
            tests++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL busy_ready: got %b expected 0", monitor_ready); end
            if (is_wr) begin
                tests++; if (mem_wdata !== data) begin fails++; $display("FAIL req_wdata: got %h expected %h", mem_wdata, data); end
            end
            mem_waitrequest = (k <= waits);
            mem_rdata = (k > waits) ? ram[mem_addr] : $urandom();
            if (k > waits && mem_wr) ram[mem_addr] = mem_wdata;
            if (k == 1) begin
                case (stray)
                    1: act_a = 1'b1;
                    2: act_b = 1'b1;
                    3: noact_a = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
            act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
            mem_waitrequest = 1'b0;
        end
        exp_cnt = acc ? waits + 1 : TO;
        if (stray != 0 || multi) m_err = 1'b1;
        if (is_wr) m_mon = data;
        if (acc) begin
            if (is_wr) ref_mem[m_addr] = data;
            else m_mon = ref_mem[m_addr];
            m_addr = m_addr + 1'b1;
        end else begin
            m_err = 1'b1;
        end
        tests++; if (k !== exp_cnt) begin fails++; $display("FAIL req_cycles: got %0d expected %0d", k, exp_cnt); end
        tests++; if ({mem_rd, mem_wr, monitor_ready} !== 3'b001) begin fails++; $display("FAIL done_idle: got %b expected 001", {mem_rd, mem_wr, monitor_ready}); end
        tests++; if (MonDReg !== m_mon) begin fails++; $display("FAIL done_mon: got %h expected %h", MonDReg, m_mon); end
        tests++; if (mem_addr !== m_addr) begin fails++; $display("FAIL done_addr: got %h expected %h", mem_addr, m_addr); end
        tests++; if (monitor_error !== m_err) begin fails++; $display("FAIL done_err: got %b expected %b", monitor_error, m_err); end
    endtask

    task automatic test_write_basic;
        do_load(8'h10, 1'b0);
        do_access(1'b1, 32'hDEADBEEF, 0, 0, 1'b0);
        tests++; if (ram[8'h10] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_stored: got %h expected deadbeef", ram[8'h10]); end
    endtask

    task automatic test_read_wait;
        ram[8'h11] = 32'h12345678;
        ref_mem[8'h11] = 32'h12345678;
        do_access(1'b0, 32'h0, 3, 0, 1'b0);
    endtask

    task automatic test_wrap;
        do_load(8'hFF, 1'b0);
        do_access(1'b0, 32'h0, 0, 0, 1'b0);
        do_access(1'b0, 32'h0, 1, 0, 1'b0);
    endtask

    task automatic test_timeout;
        do_access(1'b1, $urandom(), TO + 2, 0, 1'b0);
        do_access(1'b0, 32'h0, TO, 0, 1'b0);
        do_load(8'h20, 1'b0);
    endtask

    task automatic test_drop;
        do_access(1'b1, $urandom(), 1, 3, 1'b0);
        do_load(8'h21, 1'b0);
        do_access(1'b0, 32'h0, 2, 1, 1'b0);
        do_load(8'h22, 1'b0);
    endtask

    task automatic test_multi;
        do_load(8'h30, 1'b1);
        do_load(8'h31, 1'b0);
        do_access(1'b1, $urandom(), 0, 0, 1'b1);
        do_load(8'h32, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int op, waits, stray;
            bit multi;
            op    = $urandom_range(0, 2);
            waits = $urandom_range(0, 5);
            stray = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            multi = ($urandom_range(0, 7) == 0);
            case (op)
                0: do_load(AW'($urandom()), multi);
                1: do_access(1'b1, $urandom(), waits, stray, multi);
                default: do_access(1'b0, 32'h0, waits, stray, 1'b0);
            endcase
        end
    endtask

    task automatic test_reset_mid;
        do_load(8'h40, 1'b0);
        @(negedge clk);
        noact_a = 1'b1;
        @(negedge clk);
        noact_a = 1'b0;
        mem_waitrequest = 1'b1;
        tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL mid_rd_before: got %b expected 1", mem_rd); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++; if ({mem_rd, mem_wr} !== 2'b00) begin fails++; $display("FAIL mid_req: got %b expected 00", {mem_rd, mem_wr}); end
        tests++; if ({monitor_ready, monitor_error} !== 2'b10) begin fails++; $display("FAIL mid_status: got %b expected 10", {monitor_ready, monitor_error}); end
        tests++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL mid_mon: got %h expected 0", MonDReg); end
        tests++; if (mem_addr !== '0) begin fails++; $display("FAIL mid_addr: got %h expected 00", mem_addr); end
        @(negedge clk);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        do_access(1'b0, 32'h0, 0, 0, 1'b0);
    endtask

    initial begin
        jdo = '0; act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0;
        mem_rdata = '0; mem_waitrequest = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom();
            ref_mem[i] = ram[i];
        end
        test_reset;
        test_write_basic;
        test_read_wait;
        test_wrap;
        test_timeout;
        test_drop;
        test_multi;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
